// File: rtl/riscv_pkg.sv
// Shared constants and types for the memory-access stage.
package riscv_pkg;

    // Load/store funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_e;

    // Illegal size encodings fall back to a full-word access
    function automatic acc_size_e size_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Byte-lane handling for the memory stage: byte enables, store replication,
// alignment check and load lane extraction with sign/zero extension.
module riscv_lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    input  logic [31:0] store_data,
    input  logic [31:0] load_raw,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misalign,
    output logic [31:0] load_data
);

    logic [31:0] shifted;
    logic        is_unsigned;

    assign shifted     = load_raw >> {lane, 3'b000};
    assign is_unsigned = funct3[2];

    // Size-dependent lane logic
    always_comb begin
        be        = 4'b1111;
        wdata     = store_data;
        misalign  = 1'b0;
        load_data = load_raw;
        case (size_of(funct3))
            SZ_BYTE: begin
                be        = 4'b0001 << lane;
                wdata     = {4{store_data[7:0]}};
                load_data = is_unsigned ? {24'd0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                be        = 4'b0011 << lane;
                wdata     = {2{store_data[15:0]}};
                misalign  = lane[0];
                load_data = is_unsigned ? {16'd0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            end
            default: begin
                misalign = (lane != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/riscv_mem.sv
// Memory-access pipeline stage: runs one load/store at a time on the data
// port, stalls upstream until it completes and registers write-back data.
//
//   state | meaning
//   IDLE  | no transaction in flight; aligned op requests combinationally
//   REQ   | request presented, waiting for grant
//   WAIT  | load granted, waiting for read data
module riscv_mem
    import riscv_pkg::*;
#(
    parameter int WORD_SIZE     = 32,
    parameter int REGFILE_COUNT = 32,
    localparam int RI           = $clog2(REGFILE_COUNT)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    input  logic [WORD_SIZE-1:0] alu_out_i,
    input  logic [WORD_SIZE-1:0] read_data1_i,
    input  logic [RI-1:0]        write_reg_i,
    input  logic                 mem_read_i,
    input  logic                 mem_write_i,
    input  logic [2:0]           funct3_i,
    input  logic                 reg_write_i,
    input  logic                 branch_i,
    input  logic                 alu_zero_i,
    input  logic [WORD_SIZE-1:0] jp_addr_i,
    output logic                 stall_o,
    output logic                 pc_src_o,
    output logic [WORD_SIZE-1:0] jp_addr_o,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    output logic [WORD_SIZE-1:0] dmem_addr_o,
    output logic [3:0]           dmem_be_o,
    output logic [WORD_SIZE-1:0] dmem_wdata_o,
    input  logic                 dmem_gnt_i,
    input  logic                 dmem_rvalid_i,
    input  logic [WORD_SIZE-1:0] dmem_rdata_i,
    output logic                 valid_o,
    output logic [RI-1:0]        write_reg_o,
    output logic                 reg_write_o,
    output logic [WORD_SIZE-1:0] wb_data_o,
    output logic                 misalign_o
);

    mem_state_e     state;
    logic [3:0]     be_c;
    logic [31:0]    wdata_c;
    logic [31:0]    load_c;
    logic           misalign_c;
    logic           mem_op;
    logic           aligned_op;
    logic           store_done;

    riscv_lsu_align u_align (
        .lane       (alu_out_i[1:0]),
        .funct3     (funct3_i),
        .store_data (read_data1_i),
        .load_raw   (dmem_rdata_i),
        .be         (be_c),
        .wdata      (wdata_c),
        .misalign   (misalign_c),
        .load_data  (load_c)
    );

    assign mem_op     = valid_i & (mem_read_i | mem_write_i);
    assign aligned_op = mem_op & ~misalign_c;

    // Request, stall and branch resolution are all combinational
    always_comb begin
        dmem_req_o   = ((state == IDLE) & aligned_op) | ((state == REQ) & valid_i);
        dmem_we_o    = dmem_req_o & mem_write_i;
        store_done   = dmem_req_o & dmem_gnt_i & mem_write_i;
        stall_o      = (dmem_req_o & ~store_done) | ((state == WAIT) & ~dmem_rvalid_i);
        dmem_addr_o  = valid_i ? {alu_out_i[WORD_SIZE-1:2], 2'b00} : '0;
        dmem_be_o    = valid_i ? be_c : 4'b0000;
        dmem_wdata_o = valid_i ? wdata_c : '0;
        pc_src_o     = valid_i & branch_i & alu_zero_i;
        jp_addr_o    = valid_i ? jp_addr_i : '0;
    end

    // Transaction FSM and write-back register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            valid_o     <= 1'b0;
            reg_write_o <= 1'b0;
            misalign_o  <= 1'b0;
            write_reg_o <= '0;
            wb_data_o   <= '0;
        end else begin
            valid_o     <= 1'b0;
            reg_write_o <= 1'b0;
            misalign_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_i & ~mem_op) begin
                        valid_o     <= 1'b1;
                        wb_data_o   <= alu_out_i;
                        write_reg_o <= write_reg_i;
                        reg_write_o <= reg_write_i;
                    end else if (mem_op & misalign_c) begin
                        valid_o     <= 1'b1;
                        misalign_o  <= 1'b1;
                        wb_data_o   <= alu_out_i;
                        write_reg_o <= write_reg_i;
                    end else if (aligned_op) begin
                        if (!dmem_gnt_i) begin
                            state <= REQ;
                        end else if (mem_write_i) begin
                            valid_o     <= 1'b1;
                            wb_data_o   <= alu_out_i;
                            write_reg_o <= write_reg_i;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt_i) begin
                        if (mem_write_i) begin
                            state       <= IDLE;
                            valid_o     <= 1'b1;
                            wb_data_o   <= alu_out_i;
                            write_reg_o <= write_reg_i;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rvalid_i) begin
                        state       <= IDLE;
                        valid_o     <= 1'b1;
                        wb_data_o   <= load_c;
                        write_reg_o <= write_reg_i;
                        reg_write_o <= reg_write_i;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mem.sv
// Directed bench for the memory-access stage with hand-computed vectors.
module tb_riscv_mem;
    import riscv_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic [31:0] alu_out_i;
    logic [31:0] read_data1_i;
    logic [4:0]  write_reg_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [2:0]  funct3_i;
    logic        reg_write_i;
    logic        branch_i;
    logic        alu_zero_i;
    logic [31:0] jp_addr_i;
    logic        stall_o;
    logic        pc_src_o;
    logic [31:0] jp_addr_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        valid_o;
    logic [4:0]  write_reg_o;
    logic        reg_write_o;
    logic [31:0] wb_data_o;
    logic        misalign_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    riscv_mem dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .valid_i       (valid_i),
        .alu_out_i     (alu_out_i),
        .read_data1_i  (read_data1_i),
        .write_reg_i   (write_reg_i),
        .mem_read_i    (mem_read_i),
        .mem_write_i   (mem_write_i),
        .funct3_i      (funct3_i),
        .reg_write_i   (reg_write_i),
        .branch_i      (branch_i),
        .alu_zero_i    (alu_zero_i),
        .jp_addr_i     (jp_addr_i),
        .stall_o       (stall_o),
        .pc_src_o      (pc_src_o),
        .jp_addr_o     (jp_addr_o),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .valid_o       (valid_o),
        .write_reg_o   (write_reg_o),
        .reg_write_o   (reg_write_o),
        .wb_data_o     (wb_data_o),
        .misalign_o    (misalign_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rd, input logic rw);
        valid_i      = 1'b1;
        mem_read_i   = mr;
        mem_write_i  = mw;
        funct3_i     = f3;
        alu_out_i    = addr;
        read_data1_i = data;
        write_reg_i  = rd;
        reg_write_i  = rw;
        branch_i     = 1'b0;
        alu_zero_i   = 1'b0;
        jp_addr_i    = 32'd0;
    endtask

    task automatic idle();
        valid_i       = 1'b0;
        mem_read_i    = 1'b0;
        mem_write_i   = 1'b0;
        funct3_i      = 3'b000;
        alu_out_i     = 32'd0;
        read_data1_i  = 32'd0;
        write_reg_i   = 5'd0;
        reg_write_i   = 1'b0;
        branch_i      = 1'b0;
        alu_zero_i    = 1'b0;
        jp_addr_i     = 32'd0;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'd0;
    endtask

    initial begin
        rst_ni = 1'b0;
        idle();
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_wb", wb_data_o, 32'd0);
        check("rst_stall_req", {30'd0, stall_o, dmem_req_o}, 32'd0);
        rst_ni = 1'b1;
        tick();

        // SW 0x104, granted immediately
        drive(1'b0, 1'b1, F3_SW, 32'h104, 32'hDEADBEEF, 5'd3, 1'b0);
        dmem_gnt_i = 1'b1;
        #1;
        check("sw_req_we", {30'd0, dmem_req_o, dmem_we_o}, 32'd3);
        check("sw_be", {28'd0, dmem_be_o}, 32'hF);
        check("sw_addr", dmem_addr_o, 32'h104);
        check("sw_wdata", dmem_wdata_o, 32'hDEADBEEF);
        check("sw_stall", {31'd0, stall_o}, 32'd0);
        tick();
        check("sw_wb_valid", {31'd0, valid_o}, 32'd1);
        check("sw_wb_rw", {31'd0, reg_write_o}, 32'd0);

        // SB 0x103, grant after two stalled cycles
        drive(1'b0, 1'b1, F3_SB, 32'h103, 32'h000000A5, 5'd4, 1'b0);
        dmem_gnt_i = 1'b0;
        #1;
        check("sb_be", {28'd0, dmem_be_o}, 32'h8);
        check("sb_wdata", dmem_wdata_o, 32'hA5A5A5A5);
        check("sb_addr", dmem_addr_o, 32'h100);
        check("sb_stall_c0", {31'd0, stall_o}, 32'd1);
        tick();
        check("sb_bubble_c1", {31'd0, valid_o}, 32'd0);
        check("sb_stall_c1", {31'd0, stall_o}, 32'd1);
        check("sb_req_c1", {31'd0, dmem_req_o}, 32'd1);
        check("sb_be_c1", {28'd0, dmem_be_o}, 32'h8);
        check("sb_wdata_c1", dmem_wdata_o, 32'hA5A5A5A5);
        tick();
        dmem_gnt_i = 1'b1;
        #1;
        check("sb_stall_gnt", {31'd0, stall_o}, 32'd0);
        check("sb_req_gnt", {31'd0, dmem_req_o}, 32'd1);
        tick();
        check("sb_wb_valid", {31'd0, valid_o}, 32'd1);
        check("sb_wb_rw", {31'd0, reg_write_o}, 32'd0);

        // LB 0x101: grant one cycle late, rvalid two cycles after grant
        drive(1'b1, 1'b0, F3_LB, 32'h101, 32'd0, 5'd5, 1'b1);
        dmem_gnt_i = 1'b0;
        #1;
        check("lb_req_c0", {30'd0, dmem_req_o, dmem_we_o}, 32'd2);
        check("lb_stall_c0", {31'd0, stall_o}, 32'd1);
        tick();
        dmem_gnt_i = 1'b1;
        #1;
        check("lb_stall_c1", {31'd0, stall_o}, 32'd1);
        tick();
        dmem_gnt_i = 1'b0;
        #1;
        check("lb_stall_c2", {31'd0, stall_o}, 32'd1);
        check("lb_req_c2", {31'd0, dmem_req_o}, 32'd0);
        check("lb_bubble_c2", {31'd0, valid_o}, 32'd0);
        tick();
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h000080FF;
        #1;
        check("lb_stall_c3", {31'd0, stall_o}, 32'd0);
        tick();
        dmem_rvalid_i = 1'b0;
        check("lb_wb_valid", {31'd0, valid_o}, 32'd1);
        check("lb_wb_data", wb_data_o, 32'hFFFFFF80);
        check("lb_wb_reg", {27'd0, write_reg_o}, 32'd5);
        check("lb_wb_rw", {31'd0, reg_write_o}, 32'd1);

        // LBU 0x101, minimum latency
        drive(1'b1, 1'b0, F3_LBU, 32'h101, 32'd0, 5'd6, 1'b1);
        dmem_gnt_i = 1'b1;
        #1;
        check("lbu_stall_gnt", {31'd0, stall_o}, 32'd1);
        tick();
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h000080FF;
        check("lbu_bubble", {31'd0, valid_o}, 32'd0);
        tick();
        dmem_rvalid_i = 1'b0;
        check("lbu_wb_data", wb_data_o, 32'h00000080);

        // LH 0x102
        drive(1'b1, 1'b0, F3_LH, 32'h102, 32'd0, 5'd7, 1'b1);
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h80010000;
        tick();
        dmem_rvalid_i = 1'b0;
        check("lh_wb_data", wb_data_o, 32'hFFFF8001);
        check("lh_wb_reg", {27'd0, write_reg_o}, 32'd7);

        // LW 0x102 is misaligned: no request, no stall
        drive(1'b1, 1'b0, F3_LW, 32'h102, 32'd0, 5'd8, 1'b1);
        #1;
        check("lw_mis_req", {31'd0, dmem_req_o}, 32'd0);
        check("lw_mis_stall", {31'd0, stall_o}, 32'd0);
        tick();
        check("lw_mis_wb", {29'd0, valid_o, misalign_o, reg_write_o}, 32'b110);

        // Non-memory op
        drive(1'b0, 1'b0, 3'b000, 32'h12345678, 32'd0, 5'd10, 1'b1);
        #1;
        check("alu_req_stall", {30'd0, dmem_req_o, stall_o}, 32'd0);
        tick();
        check("alu_wb_data", wb_data_o, 32'h12345678);
        check("alu_wb_ctl", {26'd0, write_reg_o, reg_write_o}, {26'd0, 5'd10, 1'b1});
        check("alu_wb_flags", {30'd0, valid_o, misalign_o}, 32'b10);

        // SH 0x102
        drive(1'b0, 1'b1, F3_SH, 32'h102, 32'h1234BEEF, 5'd0, 1'b0);
        dmem_gnt_i = 1'b1;
        #1;
        check("sh_be", {28'd0, dmem_be_o}, 32'hC);
        check("sh_wdata", dmem_wdata_o, 32'hBEEFBEEF);
        tick();
        dmem_gnt_i = 1'b0;

        // Branch resolution
        drive(1'b0, 1'b0, 3'b000, 32'h55, 32'd0, 5'd0, 1'b0);
        branch_i   = 1'b1;
        alu_zero_i = 1'b1;
        jp_addr_i  = 32'h200;
        #1;
        check("br_taken", {31'd0, pc_src_o}, 32'd1);
        check("br_jp_addr", jp_addr_o, 32'h200);
        check("br_stall", {31'd0, stall_o}, 32'd0);
        alu_zero_i = 1'b0;
        #1;
        check("br_not_taken", {31'd0, pc_src_o}, 32'd0);
        tick();
        check("br_wb_data", wb_data_o, 32'h55);

        // Reset while a load waits for data
        drive(1'b1, 1'b0, F3_LW, 32'h200, 32'd0, 5'd9, 1'b1);
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        #1;
        check("rw_wait_stall", {30'd0, stall_o, dmem_req_o}, 32'b10);
        rst_ni = 1'b0;
        idle();
        #1;
        check("rw_rst_wb", wb_data_o, 32'd0);
        check("rw_rst_ctl", {25'd0, write_reg_o, valid_o, reg_write_o}, 32'd0);
        check("rw_rst_stall", {30'd0, stall_o, dmem_req_o}, 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hCAFEF00D;
        tick();
        dmem_rvalid_i = 1'b0;
        check("rw_late_rvalid_valid", {31'd0, valid_o}, 32'd0);
        check("rw_late_rvalid_wb", wb_data_o, 32'd0);
        check("rw_late_rvalid_stall", {31'd0, stall_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
